// File: rtl/rice_residual_decoder.sv
// Rebuilds folded Rice values u = (MSB << k) | LSB, zigzag-decodes them to signed
// residuals and queues them in a show-ahead FIFO while tracking subframe progress.
module rice_residual_decoder #(
    parameter int DEPTH = 8,
    parameter int OUT_W = 16
) (
    input  logic                    iClock,
    input  logic                    iReset,
    input  logic                    iStart,
    input  logic [15:0]             iBlockSize,
    input  logic [3:0]              iPredictorOrder,
    input  logic [15:0]             iMSB,
    input  logic [15:0]             iLSB,
    input  logic [3:0]              iRiceParam,
    input  logic                    iValid,
    output logic signed [OUT_W-1:0] oResidual,
    output logic                    oValid,
    input  logic                    iReady,
    output logic                    oAlmostFull,
    output logic                    oFrameDone,
    output logic [2:0]              oError
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} stateType;
    stateType state, stateNext;

    logic [15:0]             expected, inCount, popCount, startExpected;
    logic                    s1Valid, s2Valid;
    logic [OUT_W-1:0]        s1U, uHalf;
    logic signed [OUT_W-1:0] s2Residual, headNext;
    logic signed [OUT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]        wrPtr, rdPtr, rdPtrNext;
    logic [CNT_W-1:0]        count, countNext;
    logic [31:0]             uWide;
    logic                    rangeBad, accept, lastAccept, pop, lastPop, push, overflow;
    logic                    frameDoneNext;

    assign startExpected = iBlockSize - {12'b0, iPredictorOrder};
    assign uWide         = ({16'b0, iMSB} << iRiceParam) | {16'b0, iLSB};
    assign rangeBad      = |uWide[31:OUT_W];
    assign uHalf         = s1U >> 1;

    // iStart wins over everything else in its cycle: no accept, no pop, no write.
    assign accept     = iValid && !iStart && (state == RUN);
    assign lastAccept = accept && (inCount + 16'd1 == expected);
    assign pop        = oValid && iReady && !iStart;
    assign lastPop    = pop && (state == DRAIN) && (popCount + 16'd1 == expected);
    assign push       = s2Valid && !iStart && ((count != FULL_COUNT) || pop);
    assign overflow   = s2Valid && !iStart && (count == FULL_COUNT) && !pop;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext     = state;
        frameDoneNext = 1'b0;
        if (iStart) begin
            stateNext = (startExpected != 16'd0) ? RUN : FLUSH;
        end else begin
            case (state)
                RUN:   if (lastAccept) stateNext = DRAIN;
                DRAIN: if (lastPop) begin
                    stateNext     = IDLE;
                    frameDoneNext = 1'b1;
                end
                FLUSH: begin
                    stateNext     = IDLE;
                    frameDoneNext = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        countNext = count;
        rdPtrNext = rdPtr;
        headNext  = oResidual;
        if (iStart) begin
            countNext = '0;
            rdPtrNext = '0;
        end else begin
            if (pop) rdPtrNext = rdPtr + PTR_W'(1);
            if (push && !pop)      countNext = count + CNT_W'(1);
            else if (pop && !push) countNext = count - CNT_W'(1);
        end
        // Head register bypasses the array when the incoming word becomes the new head.
        if (countNext != '0)
            headNext = (push && (wrPtr == rdPtrNext)) ? s2Residual : mem[rdPtrNext];
    end

    // NOTE: the storage array has no reset; oValid and the head register guard its contents.
    always_ff @(posedge iClock) begin
        if (push) mem[wrPtr] <= s2Residual;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state       <= IDLE;
            expected    <= '0;
            inCount     <= '0;
            popCount    <= '0;
            s1Valid     <= 1'b0;
            s2Valid     <= 1'b0;
            s1U         <= '0;
            s2Residual  <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            oResidual   <= '0;
            oValid      <= 1'b0;
            oAlmostFull <= 1'b0;
            oFrameDone  <= 1'b0;
            oError      <= '0;
        end else begin
            state       <= stateNext;
            count       <= countNext;
            rdPtr       <= rdPtrNext;
            oResidual   <= headNext;
            oValid      <= (countNext != '0);
            oAlmostFull <= ((FULL_COUNT - countNext) <= CNT_W'(2));
            oFrameDone  <= frameDoneNext;
            oError      <= oError | {iValid && !accept, accept && rangeBad, overflow};
            s1Valid     <= accept;
            s2Valid     <= s1Valid && !iStart;
            if (accept)  s1U        <= uWide[OUT_W-1:0];
            if (s1Valid) s2Residual <= s1U[0] ? ~uHalf : uHalf;
            if (iStart) begin
                expected <= startExpected;
                inCount  <= '0;
                popCount <= '0;
                wrPtr    <= '0;
            end else begin
                if (accept) inCount  <= inCount + 16'd1;
                if (pop)    popCount <= popCount + 16'd1;
                if (push)   wrPtr    <= wrPtr + PTR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_rice_residual_decoder.sv
// Bench for rice_residual_decoder: directed phases with random triples, checked
// against an arithmetic fold/zigzag model and a queue of expected residuals.
module tb_rice_residual_decoder;
    localparam int DEPTH = 8;
    localparam int OUT_W = 16;

    logic                    iClock = 1'b0;
    logic                    iReset;
    logic                    iStart;
    logic [15:0]             iBlockSize;
    logic [3:0]              iPredictorOrder;
    logic [15:0]             iMSB;
    logic [15:0]             iLSB;
    logic [3:0]              iRiceParam;
    logic                    iValid;
    logic signed [OUT_W-1:0] oResidual;
    logic                    oValid;
    logic                    iReady;
    logic                    oAlmostFull;
    logic                    oFrameDone;
    logic [2:0]              oError;

    rice_residual_decoder #(.DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
        .iClock(iClock), .iReset(iReset), .iStart(iStart), .iBlockSize(iBlockSize),
        .iPredictorOrder(iPredictorOrder), .iMSB(iMSB), .iLSB(iLSB), .iRiceParam(iRiceParam),
        .iValid(iValid), .oResidual(oResidual), .oValid(oValid), .iReady(iReady),
        .oAlmostFull(oAlmostFull), .oFrameDone(oFrameDone), .oError(oError)
    );

    always #5 iClock = ~iClock;

    int checks = 0;
    int errors = 0;
    int model[$];
    int cycNum = 0;
    int pops = 0;
    int frameDones = 0;
    int lastPopCyc = -1;
    int frameDoneCyc = -1;

    // u = MSB * 2^k + LSB kept to 16 bits; even u -> u/2, odd u -> -(u+1)/2.
    function automatic int foldResidual(input int unsigned msb, input int unsigned lsb,
                                        input int unsigned k);
        longint unsigned u;
        int t;
        u = (64'(msb) << k) | 64'(lsb);
        t = int'(u % 65536);
        return (t % 2 == 1) ? -((t + 1) / 2) : t / 2;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        if (oValid && iReady) begin
            check("model_has_entry", int'(model.size() != 0), 1);
            if (model.size() != 0) begin
                check("residual", oResidual, model.pop_front());
                pops++;
                lastPopCyc = cycNum;
            end
        end
        @(posedge iClock);
        #1;
        cycNum++;
        if (oFrameDone) begin
            frameDones++;
            frameDoneCyc = cycNum;
        end
    endtask

    task automatic strobe(input int unsigned msb, input int unsigned lsb,
                          input int unsigned k, input int exp);
        iMSB       = 16'(msb);
        iLSB       = 16'(lsb);
        iRiceParam = 4'(k);
        iValid     = 1'b1;
        model.push_back(exp);
        cycle();
        iValid = 1'b0;
    endtask

    task automatic startFrame(input int blockSize, input int order);
        iBlockSize      = 16'(blockSize);
        iPredictorOrder = 4'(order);
        iStart          = 1'b1;
        cycle();
        iStart       = 1'b0;
        model.delete();
        pops         = 0;
        frameDones   = 0;
        lastPopCyc   = -1;
        frameDoneCyc = -1;
    endtask

    task automatic randTriple(output int unsigned msb, output int unsigned lsb,
                              output int unsigned k);
        k   = $urandom_range(0, 15);
        msb = $urandom_range(0, 32'hFFFF >> k);
        lsb = $urandom & ((32'd1 << k) - 1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && model.size() != 0; i++) cycle();
        check("drain_empty", model.size(), 0);
    endtask

    task automatic checkResetOutputs(input string phase);
        check({phase, "_residual"}, oResidual, 0);
        check({phase, "_valid"}, oValid, 0);
        check({phase, "_almost_full"}, oAlmostFull, 0);
        check({phase, "_frame_done"}, oFrameDone, 0);
        check({phase, "_error"}, oError, 0);
    endtask

    initial begin
        int unsigned m, l, k;
        int sent;
        iReset = 1'b0; iStart = 1'b0; iBlockSize = '0; iPredictorOrder = '0;
        iMSB = '0; iLSB = '0; iRiceParam = '0; iValid = 1'b0; iReady = 1'b0;

        #3;
        checkResetOutputs("reset");
        #19;
        iReset = 1'b1;
        @(posedge iClock);
        #1;

        // Fold examples, plus the two-edge latency to the FIFO head.
        iReady = 1'b1;
        startFrame(5, 0);
        strobe(3, 1, 2, -7);
        check("latency_edge0", oValid, 0);
        strobe(0, 0, 0, 0);
        check("latency_edge1", oValid, 0);
        strobe(1, 0, 0, -1);
        check("latency_edge2", oValid, 1);
        strobe(2, 0, 0, 1);
        strobe(0, 15, 4, -8);
        drain(20);
        cycle(); cycle();
        check("fold_pops", pops, 5);
        check("fold_done", frameDones, 1);
        check("fold_error", oError, 0);

        startFrame(4096, 2);
        for (int i = 0; i < 4094; i++) begin
            randTriple(m, l, k);
            strobe(m, l, k, foldResidual(m, l, k));
        end
        drain(50);
        cycle(); cycle();
        check("frame_pops", pops, 4094);
        check("frame_done_count", frameDones, 1);
        check("frame_done_timing", frameDoneCyc, lastPopCyc + 1);
        check("frame_error", oError, 0);

        // Random consumer stalls with the upstream gated on oAlmostFull.
        startFrame(300, 3);
        sent = 0;
        for (int c = 0; c < 5000 && sent < 297; c++) begin
            iReady = ($urandom_range(0, 2) != 0);
            if (!oAlmostFull && $urandom_range(0, 3) != 0) begin
                randTriple(m, l, k);
                strobe(m, l, k, foldResidual(m, l, k));
                sent++;
            end else begin
                cycle();
            end
        end
        iReady = 1'b1;
        drain(100);
        cycle(); cycle();
        check("rand_sent", sent, 297);
        check("rand_pops", pops, 297);
        check("rand_done", frameDones, 1);
        check("rand_error", oError, 0);

        iMSB = 16'd5; iValid = 1'b1;
        cycle();
        iValid = 1'b0;
        cycle(); cycle(); cycle();
        check("idle_strobe_error", oError, 3'b100);
        check("idle_strobe_valid", oValid, 0);

        startFrame(2, 2);
        check("flush_edge0", oFrameDone, 0);
        cycle();
        check("flush_edge1", oFrameDone, 1);
        cycle();
        check("flush_edge2", oFrameDone, 0);

        startFrame(1, 0);
        strobe(16'h8000, 0, 1, 0);
        drain(20);
        cycle(); cycle();
        check("range_error", oError, 3'b110);
        check("range_pops", pops, 1);
        check("range_done", frameDones, 1);

        // DEPTH+1 strobes into a stalled FIFO: entry t-2 lands after edge t.
        iReady = 1'b0;
        startFrame(DEPTH + 1, 0);
        for (int t = 1; t <= DEPTH + 4; t++) begin
            if (t <= DEPTH + 1) begin
                randTriple(m, l, k);
                strobe(m, l, k, foldResidual(m, l, k));
            end else begin
                cycle();
            end
            check("bp_almost_full", oAlmostFull, int'(t >= DEPTH));
            check("bp_overflow", oError[0], int'(t >= DEPTH + 3));
        end
        iReady = 1'b1;
        for (int i = 0; i < 40 && pops < DEPTH; i++) cycle();
        cycle(); cycle();
        check("bp_pops", pops, DEPTH);
        check("bp_no_done", frameDones, 0);
        check("bp_valid_after", oValid, 0);
        model.delete();

        startFrame(100, 0);
        for (int i = 0; i < 10; i++) begin
            randTriple(m, l, k);
            strobe(m, l, k, foldResidual(m, l, k));
        end
        iReady = 1'b0;
        cycle(); cycle();
        check("abort_pre_valid", oValid, 1);
        iValid = 1'b1;
        startFrame(3, 0);
        iValid = 1'b0;
        check("abort_valid", oValid, 0);
        check("abort_done", oFrameDone, 0);
        check("abort_almost_full", oAlmostFull, 0);
        check("abort_error", oError, 3'b111);
        iReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randTriple(m, l, k);
            strobe(m, l, k, foldResidual(m, l, k));
        end
        drain(20);
        cycle(); cycle();
        check("abort_new_pops", pops, 3);
        check("abort_new_done", frameDones, 1);

        // Asynchronous reset while DRAIN still holds entries.
        iReady = 1'b0;
        startFrame(4, 0);
        for (int i = 0; i < 4; i++) begin
            randTriple(m, l, k);
            strobe(m, l, k, foldResidual(m, l, k));
        end
        cycle(); cycle();
        check("pre_reset_valid", oValid, 1);
        #2;
        iReset = 1'b0;
        #1;
        checkResetOutputs("async_reset");
        #2;
        iReset = 1'b1;
        model.delete();
        @(posedge iClock);
        #1;
        check("post_reset_valid", oValid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
